// File: rtl/sd_pkg.sv
// Shared types, defaults and helpers for the detection event counter.
package sd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sd_state_t;

    localparam int SD_CNT_W_DEF   = 8;
    localparam int SD_WIN_DEF     = 16;
    localparam int SD_STRETCH_DEF = 4;
    localparam int SD_RATE_W      = 8;

    // Add a single detection to an 8-bit accumulator, clamping at all-ones.
    function automatic logic [SD_RATE_W-1:0] sat_add8(
        input logic [SD_RATE_W-1:0] acc,
        input logic                 inc
    );
        if (inc && (acc != {SD_RATE_W{1'b1}})) begin
            return acc + SD_RATE_W'(1);
        end
        return acc;
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Retriggerable pulse stretcher: a trigger holds the pulse high for LEN
// cycles starting on the following cycle; a new trigger restarts the count.
module pulse_stretch #(
    parameter int LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic trig,
    output logic pulse
);

    localparam int CW = $clog2(LEN + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pulse_q;

    always_comb begin
        cnt_d = cnt_q;
        if (trig) begin
            cnt_d = CW'(LEN);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= (cnt_d != '0);
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/sd_event_counter.sv
// Detection event counter: saturating total count, per-window detection rate
// and status LEDs, driven by a registered copy of the upstream detect pulse.
module sd_event_counter
    import sd_pkg::*;
#(
    parameter int CNT_W   = SD_CNT_W_DEF,
    parameter int WIN     = SD_WIN_DEF,
    parameter int STRETCH = SD_STRETCH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 det_in,
    output logic [CNT_W-1:0]     total_cnt,
    output logic                 sat,
    output logic [SD_RATE_W-1:0] win_rate,
    output logic                 win_valid,
    output logic [2:0]           led
);

    localparam logic [CNT_W-1:0]     CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [SD_RATE_W-1:0] WIN_LAST = SD_RATE_W'(WIN - 1);

    sd_state_t            state_q;
    logic                 det_q;
    logic                 hit;
    logic [CNT_W-1:0]     total_q, total_d;
    logic                 sat_q, sat_d;
    logic [SD_RATE_W-1:0] wcnt_q, wcnt_d;
    logic [SD_RATE_W-1:0] acc_q, acc_d;
    logic [SD_RATE_W-1:0] rate_q, rate_d;
    logic                 valid_q, valid_d;
    logic                 stretch_pulse;

    // det_in may come straight from a Mealy output, so only its registered
    // copy is ever used for counting.
    assign hit = (state_q == RUN) && det_q;

    always_comb begin
        total_d = total_q;
        sat_d   = sat_q;
        if (clear) begin
            total_d = '0;
            sat_d   = 1'b0;
        end else if (hit && (total_q != CNT_MAX)) begin
            total_d = total_q + CNT_W'(1);
            if (total_d == CNT_MAX) begin
                sat_d = 1'b1;
            end
        end
    end

    // Window logic idles at zero outside RUN so every new RUN period starts
    // a fresh window; clear deliberately has no effect here.
    always_comb begin
        wcnt_d  = '0;
        acc_d   = '0;
        rate_d  = rate_q;
        valid_d = 1'b0;
        if (state_q == RUN) begin
            if (wcnt_q == WIN_LAST) begin
                rate_d  = sat_add8(acc_q, hit);
                valid_d = 1'b1;
            end else begin
                wcnt_d = wcnt_q + SD_RATE_W'(1);
                acc_d  = sat_add8(acc_q, hit);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            det_q   <= 1'b0;
            total_q <= '0;
            sat_q   <= 1'b0;
            wcnt_q  <= '0;
            acc_q   <= '0;
            rate_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE:    if (enable)  state_q <= RUN;
                RUN:     if (!enable) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            det_q   <= det_in;
            total_q <= total_d;
            sat_q   <= sat_d;
            wcnt_q  <= wcnt_d;
            acc_q   <= acc_d;
            rate_q  <= rate_d;
            valid_q <= valid_d;
        end
    end

    pulse_stretch #(
        .LEN (STRETCH)
    ) u_led_stretch (
        .clk   (clk),
        .reset (reset),
        .trig  (det_q),
        .pulse (stretch_pulse)
    );

    assign total_cnt = total_q;
    assign sat       = sat_q;
    assign win_rate  = rate_q;
    assign win_valid = valid_q;
    assign led       = {(state_q == RUN), sat_q, stretch_pulse};

endmodule

// File: tb/tb_sd_event_counter.sv
// Directed bench for sd_event_counter: a behavioural reference model feeds a
// scoreboard each cycle, plus fixed-value checks at the interesting points.
module tb_sd_event_counter;

    localparam int CNT_W   = 4;
    localparam int WIN     = 16;
    localparam int STRETCH = 4;
    localparam int TMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             clear;
    logic             det_in;
    logic [CNT_W-1:0] total_cnt;
    logic             sat;
    logic [7:0]       win_rate;
    logic             win_valid;
    logic [2:0]       led;

    always #5 clk = ~clk;

    sd_event_counter #(
        .CNT_W   (CNT_W),
        .WIN     (WIN),
        .STRETCH (STRETCH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .clear     (clear),
        .det_in    (det_in),
        .total_cnt (total_cnt),
        .sat       (sat),
        .win_rate  (win_rate),
        .win_valid (win_valid),
        .led       (led)
    );

    typedef struct {
        int       total;
        bit       sat;
        int       rate;
        bit       valid;
        bit [2:0] led;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   cyc_no = 0;

    // Reference model state
    int m_total = 0, m_rate = 0, m_phase = 0, m_hits = 0, m_str = 0;
    bit m_sat = 0, m_valid = 0, m_run = 0, m_det = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc_no, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit en, input bit clr, input bit d);
        bit dv;
        if (r) begin
            m_total = 0; m_sat = 0; m_rate = 0; m_valid = 0;
            m_phase = 0; m_hits = 0; m_str = 0; m_run = 0; m_det = 0;
        end else begin
            dv = m_run && m_det;
            if (clr) begin
                m_total = 0;
                m_sat   = 0;
            end else if (dv && m_total < TMAX) begin
                m_total++;
                if (m_total == TMAX) m_sat = 1;
            end
            m_valid = 0;
            if (!m_run) begin
                m_phase = 0;
                m_hits  = 0;
            end else if (m_phase == WIN - 1) begin
                m_rate  = (m_hits + int'(dv) > 255) ? 255 : m_hits + int'(dv);
                m_valid = 1;
                m_phase = 0;
                m_hits  = 0;
            end else begin
                m_phase++;
                m_hits = (m_hits + int'(dv) > 255) ? 255 : m_hits + int'(dv);
            end
            if (m_det)          m_str = STRETCH;
            else if (m_str > 0) m_str--;
            m_run = en;
            m_det = d;
        end
    endtask

    // One clock cycle: drive, predict, wait, then compare against the prediction.
    task automatic cyc(input bit r, input bit en, input bit clr, input bit d);
        exp_t e;
        reset  = r;
        enable = en;
        clear  = clr;
        det_in = d;
        model_step(r, en, clr, d);
        e.total = m_total;
        e.sat   = m_sat;
        e.rate  = m_rate;
        e.valid = m_valid;
        e.led   = {m_run, m_sat, (m_str != 0)};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc_no++;
        e = sb_q.pop_front();
        chk("total_cnt", 32'(total_cnt), e.total);
        chk("sat",       32'(sat),       32'(e.sat));
        chk("win_rate",  32'(win_rate),  e.rate);
        chk("win_valid", 32'(win_valid), 32'(e.valid));
        chk("led",       32'(led),       32'(e.led));
        $display("cyc %0d rst=%b en=%b clr=%b det=%b | total=%0d sat=%b rate=%0d valid=%b led=%b",
                 cyc_no, r, en, clr, d, total_cnt, sat, win_rate, win_valid, led);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        clear  = 1'b0;
        det_in = 1'b0;

        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst_total", 32'(total_cnt), 0);
        chk("rst_sat",   32'(sat),       0);
        chk("rst_rate",  32'(win_rate),  0);
        chk("rst_valid", 32'(win_valid), 0);
        chk("rst_led",   32'(led),       0);

        // Pulses at 3,5,9 (then 11,13 to fill the first window with 5 hits)
        for (int c = 0; c < 33; c++) begin
            cyc(0, 1, 0, (c == 3) || (c == 5) || (c == 9) || (c == 11) || (c == 13));
            if (c == 9)  chk("lat_total_before", 32'(total_cnt), 2);
            if (c == 10) chk("lat_total_after",  32'(total_cnt), 3);
            if (c == 10) chk("run_led2",         32'(led[2]),    1);
            if (c == 16) chk("win1_valid",       32'(win_valid), 1);
            if (c == 16) chk("win1_rate",        32'(win_rate),  5);
            if (c == 17) chk("win1_strobe_end",  32'(win_valid), 0);
            if (c == 32) chk("win2_valid",       32'(win_valid), 1);
            if (c == 32) chk("win2_rate",        32'(win_rate),  0);
        end

        // clear and a registered detection in the same cycle, total_cnt=5
        cyc(0, 1, 0, 1);
        chk("pre_clear_total", 32'(total_cnt), 5);
        cyc(0, 1, 1, 0);
        chk("clear_prio_total", 32'(total_cnt), 0);
        chk("clear_prio_sat",   32'(sat),       0);

        // Pulses 2 cycles apart keep led[0] continuously high
        for (int k = 0; k < 10; k++) begin
            cyc(0, 1, 0, (k == 0) || (k == 2) || (k == 4));
            if (k >= 1 && k <= 8) chk("stretch_high", 32'(led[0]), 1);
            if (k == 9)           chk("stretch_low",  32'(led[0]), 0);
        end

        // Saturation with 17 consecutive detections, then clear
        cyc(0, 1, 1, 0);
        for (int k = 0; k < 17; k++) cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("sat_total", 32'(total_cnt), 15);
        chk("sat_flag",  32'(sat),       1);
        chk("sat_led1",  32'(led[1]),    1);
        cyc(0, 1, 1, 0);
        chk("sat_clear_total", 32'(total_cnt), 0);
        chk("sat_clear_flag",  32'(sat),       0);
        chk("sat_clear_led1",  32'(led[1]),    0);

        // enable dropped mid-window
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int j = 0; j < 8; j++) cyc(0, 1, 0, (j == 2) || (j == 4));
        for (int j = 0; j < 20; j++) begin
            cyc(0, 0, 0, (j % 3) == 0);
            chk("idle_no_valid", 32'(win_valid), 0);
        end
        chk("idle_total_hold", 32'(total_cnt), 2);
        chk("idle_led2",       32'(led[2]),    0);
        for (int j = 0; j < 17; j++) begin
            cyc(0, 1, 0, 0);
            chk("rerun_valid", 32'(win_valid), 32'(j == 16));
        end
        chk("rerun_rate", 32'(win_rate), 0);

        // reset mid-window
        for (int j = 0; j < 6; j++) cyc(0, 1, 0, j == 1);
        chk("pre_reset_total", 32'(total_cnt), 3);
        cyc(1, 1, 0, 0);
        chk("midrst_total", 32'(total_cnt), 0);
        chk("midrst_valid", 32'(win_valid), 0);
        chk("midrst_led",   32'(led),       0);
        for (int j = 0; j < 17; j++) begin
            cyc(0, 1, 0, 0);
            chk("postrst_valid", 32'(win_valid), 32'(j == 16));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
